// File: rtl/barker_corr.sv
// Serial Barker-code correlator: sliding-window agreement count, fill/search/holdoff
// framing, detection pulse and counter. Define INV_MATCH_EN to also detect inverted codes.
module barker_corr #(
   parameter int CODE_LEN = 11,
   parameter int CW       = 4,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                din,
   input  logic                din_en,
   input  logic [CODE_LEN-1:0] code,
   input  logic [CW-1:0]       threshold,
   output logic                valid,
   output logic [CW-1:0]       corr,
   output logic                polarity,
   output logic [CNT_W-1:0]    det_cnt
);

   typedef enum logic [1:0] {FILL, SEARCH, HOLDOFF} state_t;

   state_t              state, state_nxt;
   logic [CODE_LEN-1:0] sr;
   logic                vld_q;       // a bit was shifted in on the previous edge
   logic [5:0]          fcnt, hcnt;
   logic [5:0]          mis, agree, win;
   logic                tru_ok, inv_ok, hit, hit_pol;

   // 6 bits hold 0..32, so the count never overflows for any legal CODE_LEN
   always_comb begin
      mis = '0;
      for (int i = 0; i < CODE_LEN; i++)
         mis = mis + 6'(sr[i] ^ code[i]);
      agree  = 6'(CODE_LEN) - mis;
      tru_ok = 32'(agree) >= 32'(threshold);
`ifdef INV_MATCH_EN
      inv_ok = 32'(mis) >= 32'(threshold);
`else
      inv_ok = 1'b0;
`endif
   end

   // Window evaluation lags the shift by one edge; the true match takes precedence.
   always_comb begin
      state_nxt = state;
      hit       = 1'b0;
      hit_pol   = 1'b0;
      case (state)
         FILL:
            if (din_en && fcnt == 6'(CODE_LEN - 1))
               state_nxt = SEARCH;
         SEARCH:
            if (vld_q && (tru_ok || inv_ok)) begin
               hit       = 1'b1;
               hit_pol   = ~tru_ok;
               state_nxt = HOLDOFF;
            end
         HOLDOFF:
            if (vld_q && hcnt == 6'(CODE_LEN - 2))
               state_nxt = SEARCH;
         default:
            state_nxt = FILL;
      endcase
      win = (hit && hit_pol) ? mis : agree;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= FILL;
         sr       <= '0;
         vld_q    <= 1'b0;
         fcnt     <= '0;
         hcnt     <= '0;
         valid    <= 1'b0;
         corr     <= '0;
         polarity <= 1'b0;
         det_cnt  <= '0;
      end else begin
         state <= state_nxt;
         vld_q <= din_en;
         valid <= hit;
         if (din_en)
            sr <= {sr[CODE_LEN-2:0], din};
         if (state == FILL && din_en)
            fcnt <= fcnt + 6'd1;
         if (state == HOLDOFF && vld_q)
            hcnt <= (hcnt == 6'(CODE_LEN - 2)) ? '0 : hcnt + 6'd1;
         if (vld_q)
            corr <= CW'(win);
         if (hit) begin
            polarity <= hit_pol;
            det_cnt  <= det_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/barker_corr.md
BARKER_CORR -- requirements
Module: barker_corr

Interface
REQ-001 Parameter CODE_LEN, default 11: code length in bits; legal range 2..32.
REQ-002 Parameter CW, default 4: agreement-count width; SHALL satisfy 2^CW > CODE_LEN.
REQ-003 Parameter CNT_W, default 16: width of the detection counter.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 din  input  1  serial data bit; MSB of the code is expected first.
REQ-007 din_en  input  1  sample strobe; din is taken only on edges where din_en=1.
REQ-008 code  input  CODE_LEN  reference pattern; quasi-static, changes only while rst=0.
REQ-009 threshold  input  CW  minimum agreement count for a detection.
REQ-010 valid  output  1  one-clock detection pulse.
REQ-011 corr  output  CW  agreement count of the most recent window, registered.
REQ-012 polarity  output  1  0 = true code matched, 1 = inverted code matched.
REQ-013 det_cnt  output  CNT_W  running count of detections.

Function
REQ-014 The shift register SHALL load as sr <= {sr[CODE_LEN-2:0], din} on each edge with din_en=1, and SHALL hold otherwise.
REQ-015 Agreement SHALL be agree = CODE_LEN - popcount(sr ^ code), computed at full width without overflow.
REQ-016 corr SHALL update one edge after every shift, so it reflects the window that includes the newly shifted bit.
REQ-017 The FSM SHALL have three states:
- FILL: entered from reset; a fill counter counts accepted bits; move to SEARCH when the CODE_LEN-th bit is shifted in; valid is suppressed.
- SEARCH: each shift evaluates the window; if agree >= threshold, valid pulses on the following edge and the FSM enters HOLDOFF.
- HOLDOFF: suppresses detection for the next CODE_LEN-1 accepted bits (non-overlapping frames), then returns to SEARCH.
REQ-018 The evaluation for the CODE_LEN-th accepted bit SHALL already be made in SEARCH, so the earliest possible valid is one edge after the CODE_LEN-th din_en bit.
REQ-019 valid SHALL be high for exactly one clock per detection, even if din_en stays high.
REQ-020 Gaps in din_en SHALL NOT advance FILL, HOLDOFF or the window; the FSM only advances on accepted bits.
REQ-021 det_cnt SHALL increment by 1 in the same edge that valid asserts, and SHALL wrap from all-ones to 0.
REQ-022 threshold = 0 SHALL detect on every eligible window; threshold > CODE_LEN SHALL never detect.
REQ-023 polarity SHALL update only with valid and SHALL hold its value between detections.

Reset
REQ-024 While rst=0, all of the following SHALL be held at 0: sr, the fill and holdoff counters, valid, corr, polarity and det_cnt; the FSM SHALL be in FILL.
REQ-025 Reset asserted mid-frame or mid-HOLDOFF SHALL discard all partial state; after release, CODE_LEN new bits are required before any detection.
REQ-026 Reset release SHALL take effect on the first rising edge of clk with rst=1.

Configuration
REQ-027 Macro INV_MATCH_EN: when defined, a window with (CODE_LEN - agree) >= threshold SHALL also detect, with polarity=1 and corr = CODE_LEN - agree.
- If both true and inverted matches qualify in the same window, the true match SHALL win (polarity=0).
REQ-028 Without INV_MATCH_EN, polarity SHALL be constant 0 and inverted patterns SHALL NOT detect.

Verification
REQ-029 Defaults, code=11100010010, threshold=9, din_en=1, stream 11100010011_11100010001_11100010010 -> valid pulses after bits 11, 22 and 33; corr = 10, 9, 11; det_cnt ends at 3.
REQ-030 Same stream, threshold=11 -> exactly one valid, after bit 33; corr=11.
REQ-031 Exact code streamed with din_en=1 only every third clock -> one valid, one clock after the 11th accepted bit.
REQ-032 rst pulsed low after 6 code bits, then full code streamed -> no valid before 11 new bits; valid after the 11th.
REQ-033 INV_MATCH_EN defined, stream 00011101101 with threshold=10 -> valid with polarity=1, corr=11; without the macro -> no valid.
REQ-034 CNT_W=2, five detections separated by noise -> det_cnt sequence 1,2,3,0,1.
